// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW fetch path: packet geometry, memory sizing and
// the fetch FSM state encoding.
package vliw_pkg;

    localparam int SLOT_W         = 32;
    localparam int NUM_SLOTS      = 10;
    localparam int PACKET_W       = SLOT_W * NUM_SLOTS;
    localparam int IMEM_DEPTH     = 64;
    localparam int ADDR_W         = $clog2(IMEM_DEPTH);
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous packet FIFO with flush and occupancy count. The head entry
// reads as zero while the FIFO is empty.
module fetch_fifo #(
    parameter int WIDTH = 326,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && (!full || do_pop) && !flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only entries below count_q are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/vliw_fetch_unit.sv
// VLIW instruction fetch: streams packets from instruction memory into a small
// buffer for decode. Define FETCH_PERF_CNT_EN to add stall/flush counters.
module vliw_fetch_unit #(
    parameter int PACKET_W   = vliw_pkg::PACKET_W,
    parameter int ADDR_W     = vliw_pkg::ADDR_W,
    parameter int FIFO_DEPTH = vliw_pkg::FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [PACKET_W-1:0] imem_rdata,
    output logic                pkt_valid,
    input  logic                pkt_ready,
    output logic [PACKET_W-1:0] pkt_data,
    output logic [31:0]         pkt_pc,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    import vliw_pkg::*;

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + PACKET_W;

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      occupancy;
    logic                room;
    logic                end_seen;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic [ADDR_W-1:0]   head_pc;
    logic                unused_redirect_hi;

    assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];

    // Buffered plus in-flight packets must never exceed the buffer size.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign room      = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;

        end_seen   = (state_q == ST_FETCH) && inflight_q && (imem_rdata == '0);
        imem_req   = (state_q == ST_FETCH) && room && !end_seen && !redirect_valid;
        push       = (state_q == ST_FETCH) && inflight_q && !end_seen && !redirect_valid;
        inflight_d = imem_req;

        if (imem_req) begin
            pc_d          = pc_q + 1'b1;
            inflight_pc_d = pc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (end_seen) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect overrides everything, including a simultaneous start.
        if (redirect_valid) begin
            state_d = ST_FETCH;
            pc_d    = redirect_pc[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign pop = pkt_valid && pkt_ready;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({inflight_pc_q, imem_rdata}),
        .pop_i       (pop),
        .valid_o     (pkt_valid),
        .data_o      (head),
        .count_o     (fifo_count)
    );

    assign head_pc   = head[ENTRY_W-1:PACKET_W];
    assign pkt_data  = head[PACKET_W-1:0];
    assign pkt_pc    = {{(32 - ADDR_W){1'b0}}, head_pc};
    assign imem_addr = pc_q;
    assign busy      = !((state_q == ST_IDLE) ||
                         ((state_q == ST_HALT) && (fifo_count == '0) && !inflight_q));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pkt_valid && !pkt_ready) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
            if (redirect_valid) begin
                flush_cnt_q <= sat_inc32(flush_cnt_q);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Self-checking bench for vliw_fetch_unit: cycle table for the basic program run,
// scoreboard of expected packet indices for the multi-cycle scenarios.
module tb_vliw_fetch_unit;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         imem_req;
    logic [5:0]   imem_addr;
    logic [319:0] imem_rdata;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [319:0] pkt_data;
    logic [31:0]  pkt_pc;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  perf_stall_cnt;
    logic [31:0]  perf_flush_cnt;
`endif

    vliw_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_data       (pkt_data),
        .pkt_pc         (pkt_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int req_cnt  = 0;
    bit sb_en    = 1'b1;
    int sb_q[$];
    logic [319:0] mem [64];

    typedef struct {
        logic       start;
        logic       ready;
        logic       exp_req;
        logic [5:0] exp_addr;
        logic       exp_valid;
        logic [5:0] exp_pc;
        logic       exp_busy;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [319:0] make_pkt(input int idx);
        logic [319:0] p;
        for (int s = 0; s < 10; s++) begin
            p[319 - 32*s -: 32] = {8'(idx), 8'(s), 16'hC0DE};
        end
        return p;
    endfunction

    // Instruction memory: data returned one cycle after the request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem[imem_addr] : '0;
    end

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts requests and checks every transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) req_cnt++;
            if (sb_en && pkt_valid && pkt_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_pkt", pkt_pc, 32'hFFFF_FFFF);
                end else begin
                    int e;
                    e = sb_q.pop_front();
                    $display("xfer pc=%0d expected %0d", pkt_pc, e);
                    chk("sb_pc", pkt_pc, e);
                    chk("sb_data", pkt_data, make_pkt(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        start = 1'b0;
        pkt_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        req_cnt = 0;
    endtask

    task automatic load_mem(input int halt_at);
        for (int i = 0; i < 64; i++) mem[i] = make_pkt(i);
        mem[halt_at] = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        $display("%s: reset outputs req=%0d addr=%0d valid=%0d pc=%0d busy=%0d",
                 tag, imem_req, imem_addr, pkt_valid, pkt_pc, busy);
        chk({tag, "_imem_req"}, imem_req, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_pkt_valid"}, pkt_valid, 0);
        chk({tag, "_pkt_data"}, pkt_data, 0);
        chk({tag, "_pkt_pc"}, pkt_pc, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", busy, 0);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pkt_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_rdata = '0;

        // Program run: 0..5 valid, 6 ends the program, ready held high.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 6'd0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 6'd2, 1'b1, 6'd0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 6'd1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 6'd4, 1'b1, 6'd2, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 6'd3, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 6'd6, 1'b1, 6'd4, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'd7, 1'b1, 6'd5, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'd7, 1'b0, 6'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 6'd7, 1'b0, 6'd0, 1'b0};

        // Basic program run with cycle-exact expectations
        reset_dut();
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        load_mem(6);
        for (int i = 0; i < 6; i++) sb_q.push_back(i);
        for (int k = 0; k < 11; k++) begin
            start = vecs[k].start;
            pkt_ready = vecs[k].ready;
            @(negedge clk);
            $display("cyc %0d: req=%0d addr=%0d valid=%0d pc=%0d busy=%0d",
                     k, imem_req, imem_addr, pkt_valid, pkt_pc, busy);
            chk($sformatf("tbl%0d_req", k), imem_req, vecs[k].exp_req);
            chk($sformatf("tbl%0d_addr", k), imem_addr, vecs[k].exp_addr);
            chk($sformatf("tbl%0d_valid", k), pkt_valid, vecs[k].exp_valid);
            chk($sformatf("tbl%0d_busy", k), busy, vecs[k].exp_busy);
            if (vecs[k].exp_valid) begin
                chk($sformatf("tbl%0d_pc", k), pkt_pc, vecs[k].exp_pc);
                chk($sformatf("tbl%0d_data", k), pkt_data, make_pkt(int'(vecs[k].exp_pc)));
            end
            @(posedge clk);
            #1;
        end
        chk("run_sb_drained", sb_q.size(), 0);

        // Backpressure: ready low, buffer fills to four, then drains in order
        reset_dut();
        load_mem(12);
        for (int i = 0; i < 12; i++) sb_q.push_back(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            $display("stall cyc %0d: req=%0d valid=%0d pc=%0d", k + 5, imem_req, pkt_valid, pkt_pc);
            chk("bp_req_low", imem_req, 0);
            chk("bp_valid", pkt_valid, 1);
            chk("bp_pc_stable", pkt_pc, 0);
            chk("bp_data_stable", pkt_data, make_pkt(0));
            tick();
        end
        chk("bp_req_count", req_cnt, 4);
        pkt_ready = 1'b1;
        wait_idle(80);

        // Redirect while two packets are buffered
        reset_dut();
        load_mem(44);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        @(negedge clk);
        $display("redirect cyc: valid=%0d pc=%0d req=%0d", pkt_valid, pkt_pc, imem_req);
        chk("rd_pre_valid", pkt_valid, 1);
        chk("rd_pre_head", pkt_pc, 0);
        chk("rd_req_gated", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        pkt_ready = 1'b1;
        for (int i = 40; i < 44; i++) sb_q.push_back(i);
        @(negedge clk);
        $display("after redirect: valid=%0d req=%0d addr=%0d", pkt_valid, imem_req, imem_addr);
        chk("rd_valid_low", pkt_valid, 0);
        chk("rd_req", imem_req, 1);
        chk("rd_addr", imem_addr, 40);
        wait_idle(60);

        // Redirect to 62 together with start in IDLE; index wraps 63 -> 0
        reset_dut();
        load_mem(2);
        sb_q.push_back(62);
        sb_q.push_back(63);
        sb_q.push_back(0);
        sb_q.push_back(1);
        pkt_ready = 1'b1;
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd62;
        tick();
        start = 1'b0;
        redirect_valid = 1'b0;
        wait_idle(40);

        // Reset pulse while a request is in flight
        reset_dut();
        load_mem(20);
        pkt_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("midrst");
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("midrst_no_pkt", pkt_valid, 0);
            chk("midrst_no_req", imem_req, 0);
        end
        chk("midrst_sb_empty", sb_q.size(), 0);

`ifdef FETCH_PERF_CNT_EN
        // Performance counters: seven stall cycles, two redirects
        reset_dut();
        @(negedge clk);
        chk("perf_stall_rst", perf_stall_cnt, 0);
        chk("perf_flush_rst", perf_flush_cnt, 0);
        load_mem(30);
        sb_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        pkt_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        repeat (2) tick();
        redirect_valid = 1'b0;
        wait_idle(80);
        $display("perf: stall=%0d flush=%0d", perf_stall_cnt, perf_flush_cnt);
        chk("perf_stall", perf_stall_cnt, 7);
        chk("perf_flush", perf_flush_cnt, 2);
        sb_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vliw_fetch_unit.md
VLIW_FETCH_UNIT -- requirements
Module: vliw_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 Parameter: PACKET_W, 320, width of one 10-slot instruction packet.
REQ-003 Parameter: ADDR_W, 6, instruction memory index width (64 packets).
REQ-004 Parameter: FIFO_DEPTH, 4, packet buffer entries (power of two, >=2).
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst_n  in  1  synchronous active-low reset.
REQ-007 Port: start  in  1  begin fetching at packet 0; honoured only in IDLE.
REQ-008 Port: imem_req  out  1  read strobe to instruction memory.
REQ-009 Port: imem_addr  out  ADDR_W  packet index being read.
REQ-010 Port: imem_rdata  in  PACKET_W  read data, valid exactly one cycle after imem_req.
REQ-011 Port: pkt_valid  out  1  packet available to decode stage.
REQ-012 Port: pkt_ready  in  1  decode stage accepts packet.
REQ-013 Port: pkt_data  out  PACKET_W  packet, slot 0 in bits [319:288].
REQ-014 Port: pkt_pc  out  32  zero-extended packet index of pkt_data (decode mirrors it into r31).
REQ-015 Port: redirect_valid  in  1  branch/flush request.
REQ-016 Port: redirect_pc  in  32  new fetch index; bits [ADDR_W-1:0] used.
REQ-017 Port: busy  out  1  high unless state IDLE, or state HALT with FIFO empty and nothing in flight.

Function
REQ-018 States SHALL be IDLE, FETCH, HALT; reset state IDLE.
REQ-019 IDLE->FETCH on start (pc=0) or redirect_valid (pc=redirect_pc); start outside IDLE ignored.
REQ-020 In FETCH, imem_req SHALL assert with imem_addr=pc when fifo_count+inflight < FIFO_DEPTH (inflight 0/1); pc increments after each request.
REQ-021 pc SHALL wrap 63->0 (mod 2^ADDR_W) without halting.
REQ-022 Returned data SHALL be pushed with its pc the cycle after the request; start at cycle 0 gives imem_req at 1, pkt_valid at 3.
REQ-023 An all-zero returned packet is end-of-program: it SHALL NOT be pushed, state ->HALT, no further requests; buffered packets still drain.
REQ-024 Handshake: transfer when pkt_valid&&pkt_ready; pkt_data/pkt_pc SHALL hold stable while pkt_valid&&!pkt_ready; no combinational ready->valid path.
REQ-025 With pkt_ready held high and nonzero packets, throughput SHALL be one packet per cycle in steady state.
REQ-026 redirect_valid (any state) SHALL clear the FIFO, discard the in-flight response, load pc, enter FETCH; pkt_valid low the next cycle; first new imem_req the next cycle.
REQ-027 Redirect coincident with a transfer: the transfer completes, redirect still flushes; redirect coincident with start in IDLE: redirect wins.
REQ-028 HALT exits only via redirect.

Reset
REQ-029 With rst_n low at a clk edge: state IDLE, pc 0, FIFO empty, inflight 0, imem_req 0, imem_addr 0, pkt_valid 0, pkt_data 0, pkt_pc 0, busy 0.
REQ-030 Reset mid-operation SHALL cause the memory response arriving the next cycle to be discarded.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: add outputs perf_stall_cnt (32, cycles with pkt_valid&&!pkt_ready) and perf_flush_cnt (32, accepted redirects), saturating, reset to 0.
REQ-032 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package vliw_pkg SHALL hold PACKET_W, SLOT_W=32, NUM_SLOTS=10, IMEM_DEPTH=64, ADDR_W, and the fetch_state_t enum.
REQ-034 Packet buffer SHALL be a sub-module fetch_fifo (synchronous FIFO with flush, count output) storing {pc, packet}.

Verification
REQ-035 Reset, start at cycle 0, packets 0..5 nonzero, 6 zero, ready high -> pkt_pc 0..5 on cycles 3..8, state HALT, busy low at cycle 9.
REQ-036 pkt_ready low 10 cycles -> exactly 4 buffered, imem_req low while full, pkt_data stable; release -> all in order, no loss.
REQ-037 Redirect to 40 while FIFO holds 2 -> both dropped, imem_addr=40 next cycle, next pkt_pc=40.
REQ-038 Start at redirect_pc=62, ready high -> pkt_pc sequence 62,63,0,1.
REQ-039 rst_n low one cycle with inflight=1 -> no packet delivered, all outputs at reset values.
REQ-040 FETCH_PERF_CNT_EN: 7 stall cycles, 2 redirects -> perf_stall_cnt=7, perf_flush_cnt=2.
